// File: rtl/core_dmem_sram.sv
// ---------------------------------------------------------------------------
// core_dmem_sram
// Data-memory SRAM model with a req/gnt handshake and configurable wait
// states. One request is serviced at a time: it is accepted in IDLE, held
// through WAIT_CYCLES wait states, and completed by a single-cycle grant in
// RESP. Writes are byte-strobed and commit at the edge that ends RESP.
//
// Parameters
//   DEPTH        number of 64-bit words (power of two, 2..65536)
//   WAIT_CYCLES  wait states inserted before each grant (0..15)
//   BASE         byte address of word 0, aligned to DEPTH*8
//
// Ports
//   g_clk       in   1   clock, rising edge
//   g_resetn    in   1   synchronous active-low reset
//   dmem_req    in   1   request valid, held with stable fields until grant
//   dmem_addr   in  64   request byte address (bits [2:0] ignored)
//   dmem_wen    in   1   1 = write, 0 = read
//   dmem_strb   in   8   byte write strobes
//   dmem_wdata  in  64   write data
//   dmem_gnt    out  1   one-cycle completion of the held request
//   dmem_err    out  1   out-of-range access, valid with dmem_gnt
//   dmem_rdata  out 64   read data, valid with dmem_gnt, else 0
// ---------------------------------------------------------------------------
module core_dmem_sram #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [63:0] BASE        = 64'h0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dmem_req,
  input  logic [63:0] dmem_addr,
  input  logic        dmem_wen,
  input  logic [7:0]  dmem_strb,
  input  logic [63:0] dmem_wdata,
  output logic        dmem_gnt,
  output logic        dmem_err,
  output logic [63:0] dmem_rdata
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = 4;
  localparam int unsigned DW   = 64;
  localparam int unsigned SW   = 8;
  localparam logic [CW-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? CW'(0) : CW'(WAIT_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if ((DEPTH < 2) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("core_dmem_sram: DEPTH must be a power of two in 2..65536");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("core_dmem_sram: WAIT_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [AW-1:0]   idx_q,   idx_d;
  logic            inr_q,   inr_d;
  logic            wen_q,   wen_d;
  logic [SW-1:0]   strb_q,  strb_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            gnt_q,   gnt_d;
  logic            err_q,   err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [DW-1:0]   mem [DEPTH];

  // Address decode of the live request: word index and range check
  logic [63:0]     off_c;
  logic            inr_c;
  logic [AW-1:0]   idx_c;
  logic [2:0]      unused_off_lsb;

  assign off_c          = dmem_addr - BASE;
  assign inr_c          = (dmem_addr >= BASE) && (off_c[63:AW+3] == '0);
  assign idx_c          = off_c[AW+2:3];
  assign unused_off_lsb = off_c[2:0];

  // Response source: live inputs when granting straight from IDLE, captured
  // fields when granting out of WAIT.
  logic            src_inr;
  logic            src_wen;
  logic [AW-1:0]   src_idx;

  assign src_inr = (state_q == ST_IDLE) ? inr_c    : inr_q;
  assign src_wen = (state_q == ST_IDLE) ? dmem_wen : wen_q;
  assign src_idx = (state_q == ST_IDLE) ? idx_c    : idx_q;

  // Next-state, capture and registered-response logic
  logic resp_go;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    inr_d   = inr_q;
    wen_d   = wen_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    gnt_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    resp_go = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dmem_req) begin
          idx_d   = idx_c;
          inr_d   = inr_c;
          wen_d   = dmem_wen;
          strb_d  = dmem_strb;
          wdata_d = dmem_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            resp_go = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // A dropped request abandons the transaction without a grant
        if (!dmem_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        // The request seen here is the one being completed; never re-accept
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Response registers load on the edge that enters RESP
    if (resp_go) begin
      gnt_d = 1'b1;
      err_d = ~src_inr;
      if (src_inr && !src_wen) begin
        rdata_d = mem[src_idx];
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      inr_q   <= 1'b0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      inr_q   <= inr_d;
      wen_q   <= wen_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Write commit at the edge ending RESP; suppressed by a reset at that edge
  logic wr_en;

  assign wr_en = g_resetn && (state_q == ST_RESP) && wen_q && inr_q;

  // Backing store: no reset, byte-granular write
  always_ff @(posedge g_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (strb_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign dmem_gnt   = gnt_q;
  assign dmem_err   = err_q;
  assign dmem_rdata = rdata_q;

endmodule
